// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter: FSM encoding and opcode legality.
package alu_pkg;

  localparam int unsigned CARD_W = 5;
  localparam int unsigned STAT_W = 16;

  localparam logic [CARD_W-1:0] CARD_MIN = 5'd1;
  localparam logic [CARD_W-1:0] CARD_MAX = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // An opcode is issued to the ALU only when it lies in CARD_MIN..CARD_MAX.
  function automatic logic card_legal(input logic [CARD_W-1:0] card);
    return (card >= CARD_MIN) && (card <= CARD_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  // Pass one covers ptr..N-1, pass two wraps to 0..ptr-1.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        grant[i] = 1'b1;
        index    = IW'(i);
        any      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        grant[i] = 1'b1;
        index    = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters.
// Optional per-requester statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  input  logic [NREQ*CARD_W-1:0]   req_card,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_cin,
  output logic [CARD_W-1:0]        alu_card,
  input  logic [WIDTH-1:0]         alu_f,
  input  logic                     alu_cout,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_f,
  output logic                     rsp_cout,
  output logic                     rsp_zero,
  output logic                     rsp_err,
  output logic                     busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]   stat_ops,
  output logic [STAT_W-1:0]        stat_err
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_nxt;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     win;
  logic               any;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_cin;
  logic [CARD_W-1:0]  sel_card;
  logic               sel_legal;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .index (win),
    .any   (any)
  );

  // Ready is offered only while idle and never while reset is asserted.
  assign req_ready = (rst_n && (state_q == ST_IDLE) && any) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_nxt   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);

  // One-hot grant selects the winner's payload.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    sel_card = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = req_a[i*WIDTH +: WIDTH];
        sel_b    = req_b[i*WIDTH +: WIDTH];
        sel_cin  = req_cin[i];
        sel_card = req_card[i*CARD_W +: CARD_W];
      end
    end
    sel_legal = card_legal(sel_card);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = sel_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

  // Operand latch on accept; result capture after the single ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      alu_card <= '0;
      rsp_id   <= '0;
      rsp_f    <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_cin  <= sel_cin;
        alu_card <= sel_card;
        rsp_id   <= win;
        if (!sel_legal) begin
          rsp_err  <= 1'b1;
          rsp_f    <= '0;
          rsp_cout <= 1'b0;
          rsp_zero <= 1'b0;
        end
      end
      if (state_q == ST_ISSUE) begin
        rsp_f    <= alu_f;
        rsp_cout <= alu_cout;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid & rsp_ready;

  // Saturating per-requester counters of completed legal ops.
  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (rsp_hs && !rsp_err && (rsp_id == IDW'(g)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + STAT_W'(1);
      end
    end
    assign stat_ops[g*STAT_W +: STAT_W] = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_err <= '0;
    end else if (rsp_hs && rsp_err && (stat_err != '1)) begin
      stat_err <= stat_err + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, cycle-level scoreboard and corner sequences.
module tb_alu_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDW   = 3;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_RESP = 2;

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
  } alu_res_t;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [4:0]       card;
    logic             err;
    alu_res_t         r;
  } exp_t;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [4:0]       card;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
    logic             err;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         req_cin;
  logic [NREQ*5-1:0]       req_card;
  logic [WIDTH-1:0]        alu_a, alu_b, alu_f;
  logic                    alu_cin, alu_cout, alu_zero;
  logic [4:0]              alu_card;
  logic                    rsp_valid, rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [WIDTH-1:0]        rsp_f;
  logic                    rsp_cout, rsp_zero, rsp_err, busy;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*16-1:0]      stat_ops;
  logic [15:0]             stat_err;
`endif

  logic [WIDTH-1:0] pa [NREQ];
  logic [WIDTH-1:0] pb [NREQ];
  logic             pcin [NREQ];
  logic [4:0]       pcard [NREQ];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_state = M_IDLE;
  int   m_ptr = 0;
  int   last_grant_cyc = 0;
  int   last_hs_cyc = 0;
  exp_t sbq[$];
  int   grant_log[$];
  int   rsp_log[$];
  int   hs_log[$];
  vec_t vt[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_card(req_card),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_card(alu_card),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_err(stat_err)
`endif
  );

  // Reference ALU standing in for the external instance.
  function automatic alu_res_t alu_fn(input logic [4:0] card, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH:0] s;
    alu_res_t r;
    case (card)
      5'd1:    s = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
      5'd2:    s = {a >= b, a - b};
      5'd3:    s = {1'b0, a & b};
      5'd4:    s = {1'b0, a | b};
      5'd5:    s = {1'b0, a ^ b};
      5'd6:    s = {1'b0, ~a};
      5'd7:    s = {a, 1'b0};
      5'd8:    s = {a[0], 1'b0, a[WIDTH-1:1]};
      default: s = {1'b0, a + WIDTH'(card)};
    endcase
    r.f    = s[WIDTH-1:0];
    r.cout = s[WIDTH];
    r.zero = (s[WIDTH-1:0] == '0);
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always_comb begin
    alu_res_t r;
    r        = alu_fn(alu_card, alu_a, alu_b, alu_cin);
    alu_f    = r.f;
    alu_cout = r.cout;
    alu_zero = r.zero;
  end

  always_comb begin
    req_a = '0; req_b = '0; req_cin = '0; req_card = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = pa[i];
      req_b[i*WIDTH +: WIDTH] = pb[i];
      req_cin[i]              = pcin[i];
      req_card[i*5 +: 5]      = pcard[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Cycle-level scoreboard: predicts handshake, state and payload at every falling edge.
  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    if (!rst_n) begin
      chk("reset_ctrl", {req_ready, rsp_valid, busy, rsp_err, rsp_cout, rsp_zero, alu_cin, alu_card, rsp_id}, '0);
      chk("reset_alu_ab", {alu_a, alu_b}, '0);
      chk("reset_rsp_f", 64'(rsp_f), '0);
      m_state = M_IDLE;
      m_ptr   = 0;
      sbq.delete();
    end else begin
      w = rr_pick(req_valid, m_ptr);
      exp_rdy = '0;
      if (m_state == M_IDLE && w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_state == M_RESP));
      chk("busy", 64'(busy), 64'(m_state != M_IDLE));
      case (m_state)
        M_ISSUE: begin
          e = sbq[0];
          chk("alu_a", 64'(alu_a), 64'(e.a));
          chk("alu_b", 64'(alu_b), 64'(e.b));
          chk("alu_cin_card", {alu_cin, alu_card}, {e.cin, e.card});
          m_state = M_RESP;
        end
        M_RESP: begin
          e = sbq[0];
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_f", 64'(rsp_f), e.err ? 64'(0) : 64'(e.r.f));
          chk("rsp_flags", {rsp_cout, rsp_zero, rsp_err},
              e.err ? 64'(3'b001) : 64'({e.r.cout, e.r.zero, 1'b0}));
          if (rsp_ready) begin
            rsp_log.push_back(int'(rsp_id));
            hs_log.push_back(cyc);
            last_hs_cyc = cyc;
            void'(sbq.pop_front());
            m_state = M_IDLE;
          end
        end
        default: begin
          if (w >= 0) begin
            e.id   = w;
            e.a    = pa[w];
            e.b    = pb[w];
            e.cin  = pcin[w];
            e.card = pcard[w];
            e.err  = !(pcard[w] >= 5'd1 && pcard[w] <= 5'd16);
            e.r    = alu_fn(pcard[w], pa[w], pb[w], pcin[w]);
            sbq.push_back(e);
            grant_log.push_back(w);
            last_grant_cyc = cyc;
            m_ptr   = (w + 1) % NREQ;
            m_state = e.err ? M_RESP : M_ISSUE;
          end
        end
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [4:0] card);
    bit got = 0;
    @(posedge clk); #1;
    pa[id] = a; pb[id] = b; pcin[id] = cin; pcard[id] = card;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; break; end
    end
    if (!got) fail("grant_timeout");
    @(posedge clk); #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) fail("rsp_timeout");
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (m_state == M_IDLE && sbq.size() == 0) begin done = 1; break; end
    end
    if (!done) fail("drain_timeout");
  endtask

  initial begin
    int g0, h0, gcyc;
    bit ok, got;
    int exp_order[5];

    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; pcin[i] = 1'b0; pcard[i] = '0;
    end

    //        id  a             b             cin  card   f             cout zero err
    vt[0]  = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd1,  32'h00000001, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1, 32'h00000005, 32'h00000003, 1'b0, 5'd2,  32'h00000002, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{2, 32'h0000F0F0, 32'h00000FF0, 1'b0, 5'd3,  32'h000000F0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{3, 32'h00000000, 32'h00000000, 1'b0, 5'd4,  32'h00000000, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{2, 32'h00001234, 32'h00005678, 1'b1, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{2, 32'h00001234, 32'h00005678, 1'b0, 5'd17, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1, 32'h12345678, 32'h12345678, 1'b0, 5'd5,  32'h00000000, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{0, 32'h00000000, 32'h0000FFFF, 1'b0, 5'd6,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{3, 32'h80000001, 32'h00000000, 1'b0, 5'd7,  32'h00000002, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1, 32'h00000003, 32'h00000000, 1'b0, 5'd8,  32'h00000001, 1'b1, 1'b0, 1'b0};
    vt[10] = '{0, 32'h00000010, 32'h00000000, 1'b0, 5'd16, 32'h00000020, 1'b0, 1'b0, 1'b0};
    vt[11] = '{3, 32'h00000007, 32'h00000007, 1'b0, 5'd31, 32'h00000000, 1'b0, 1'b0, 1'b1};

    do_reset();

    // Single-op vectors, including illegal-opcode boundaries 0, 17, 31 and legal 16.
    for (int v = 0; v < 12; v++) begin
      issue_op(vt[v].id, vt[v].a, vt[v].b, vt[v].cin, vt[v].card);
      wait_rsp(ok);
      if (ok) begin
        chk($sformatf("vec%0d_latency", v), 64'(cyc - last_grant_cyc), vt[v].err ? 64'(1) : 64'(2));
        chk($sformatf("vec%0d_id", v), 64'(rsp_id), 64'(vt[v].id));
        chk($sformatf("vec%0d_f", v), 64'(rsp_f), 64'(vt[v].f));
        chk($sformatf("vec%0d_flags", v), {rsp_cout, rsp_zero, rsp_err},
            {vt[v].cout, vt[v].zero, vt[v].err});
      end
      drain();
    end

    // All four requesters valid back to back from pointer 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = WIDTH'(i * 17 + 1); pb[i] = WIDTH'(i + 2); pcin[i] = 1'b0; pcard[i] = 5'(i + 1);
    end
    g0 = grant_log.size();
    h0 = hs_log.size();
    @(posedge clk); #1 req_valid = '1;
    got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (grant_log.size() >= g0 + 5) begin got = 1; break; end
    end
    if (!got) fail("rr_grant_timeout");
    @(posedge clk); #1 req_valid = '0;
    drain();
    exp_order = '{0, 1, 2, 3, 0};
    if (grant_log.size() >= g0 + 5 && hs_log.size() >= h0 + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_grant%0d", k), 64'(grant_log[g0 + k]), 64'(exp_order[k]));
        chk($sformatf("rr_rsp_id%0d", k), 64'(rsp_log[h0 + k]), 64'(exp_order[k]));
        if (k > 0) chk($sformatf("rr_spacing%0d", k), 64'(hs_log[h0 + k] - hs_log[h0 + k - 1]), 64'(3));
      end
    end else begin
      fail("rr_log_short");
    end

    // Backpressure: response held for 5 cycles while another requester waits.
    rsp_ready = 1'b0;
    issue_op(1, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 5'd3);
    pa[2] = 32'h00000009; pb[2] = 32'h00000006; pcin[2] = 1'b0; pcard[2] = 5'd4;
    req_valid[2] = 1'b1;
    wait_rsp(ok);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {rsp_valid, busy, req_ready}, {1'b1, 1'b1, 4'b0000});
      chk("bp_rsp_f", 64'(rsp_f), 64'(32'h0F000F00));
      chk("bp_rsp_id", 64'(rsp_id), 64'(1));
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[2]) begin got = 1; gcyc = cyc; break; end
    end
    if (!got) fail("bp_grant_timeout");
    else chk("bp_accept_after_hs", 64'(gcyc - last_hs_cyc), 64'(1));
    @(posedge clk); #1 req_valid[2] = 1'b0;
    drain();

    // Reset asserted during ISSUE with requester 1 waiting.
    issue_op(0, 32'h00000001, 32'h00000001, 1'b0, 5'd1);
    pa[1] = 32'h00000040; pb[1] = 32'h00000004; pcin[1] = 1'b0; pcard[1] = 5'd2;
    req_valid[1] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {req_ready, rsp_valid, busy, rsp_err, rsp_cout, rsp_zero, alu_cin, alu_card, rsp_id}, '0);
    chk("midrst_alu", {alu_a, alu_b}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    g0 = grant_log.size();
    h0 = rsp_log.size();
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[1]) begin got = 1; break; end
    end
    if (!got) fail("midrst_grant_timeout");
    @(posedge clk); #1 req_valid[1] = 1'b0;
    drain();
    if (grant_log.size() > g0 && rsp_log.size() > h0) begin
      chk("midrst_first_grant", 64'(grant_log[g0]), 64'(1));
      chk("midrst_first_rsp", 64'(rsp_log[h0]), 64'(1));
      chk("midrst_rsp_count", 64'(rsp_log.size() - h0), 64'(1));
    end else begin
      fail("midrst_no_response");
    end

`ifdef ALU_ARB_STATS_EN
    do_reset();
    chk("stat_reset", {stat_ops, stat_err}, '0);
    for (int k = 0; k < 3; k++) begin
      issue_op(1, 32'(k), 32'h1, 1'b0, 5'd1);
      drain();
    end
    issue_op(3, 32'h5, 32'h5, 1'b0, 5'd20);
    drain();
    chk("stat_ops0", 64'(stat_ops[15:0]), 64'(0));
    chk("stat_ops1", 64'(stat_ops[31:16]), 64'(3));
    chk("stat_ops2", 64'(stat_ops[47:32]), 64'(0));
    chk("stat_ops3", 64'(stat_ops[63:48]), 64'(0));
    chk("stat_err", 64'(stat_err), 64'(1));
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (A, B, Cin, 5-bit Card in; F, Cout, Zero out) between NREQ requesters.
- Each requester presents an operation on a valid/ready handshake.
- Round-robin grant; operands are registered and driven to the ALU, and the ALU outputs are captured.
- The result is returned on a single response channel tagged with the requester id.
- Sits between the issuing units and the ALU instance, which is external to this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width; must match the ALU.
- IDW, 3, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_cin  in  NREQ  carry-in
- req_card  in  NREQ*5  opcode, requester i at [i*5 +: 5]
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_cin  out  1  registered carry-in to ALU
- alu_card  out  5  registered opcode to ALU
- alu_f  in  WIDTH  ALU result
- alu_cout  in  1  ALU carry-out
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester that issued the op
- rsp_f  out  WIDTH  captured result
- rsp_cout  out  1  captured carry-out
- rsp_zero  out  1  captured zero flag
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, rr pointer=0.
  - All outputs 0: req_ready, alu_*, rsp_*, busy.
  - Any in-flight op is dropped silently.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - req_ready = one-hot grant of the round-robin winner among req_valid; zero if none valid.
  - Transfer occurs when req_valid[i] & req_ready[i].
  - On transfer, latch the winner's a/b/cin/card into alu_* and its index into rsp_id.
  - Card in 1..16: go to ISSUE.
  - Card 0 or 17..31: do not issue; set rsp_err=1, rsp_f=0, rsp_cout=0, rsp_zero=0; go to RESP.
- ISSUE (exactly 1 cycle): alu_* stable; at the clock edge capture alu_f/alu_cout/alu_zero into rsp_*, set rsp_err=0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE and drop rsp_valid.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid high from T+2 (T+1 for an illegal opcode).
  - Maximum throughput is 1 op per 3 cycles; no pipelining.
- Round robin:
  - Search starts at the pointer and wraps modulo NREQ.
  - After a grant to i, pointer = (i+1) mod NREQ.
  - The pointer is unchanged when there is no grant.
- req_ready is 0 in ISSUE and RESP; requests wait, nothing is queued.
- alu_* keep their last values after completion; they are not cleared.
- Requester i may hold valid across cycles without the grant; its payload must stay stable until accepted.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: adds outputs stat_ops (NREQ*16, per-requester count of completed legal ops) and stat_err (16, count of illegal-opcode responses).
  - Each counter increments on the rsp handshake.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: no counters, no extra ports; all other behaviour identical.

Decomposition:
- Package alu_pkg holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - CARD_MIN=5'd1 and CARD_MAX=5'd16.
  - Card width constant 5.
- Sub-module rr_arbiter (params N; inputs req[N-1:0], ptr; outputs one-hot grant, index) is the natural split.
- Operand muxing and the FSM stay in alu_arbiter.

Test Plan:
- Single requester 0: A=32'hFFFFFFFF, B=1, Cin=1, Card=5'b00001.
  - Expect alu_* driven at T+1.
  - Expect rsp_valid at T+2 with rsp_id=0 and rsp_f/rsp_cout/rsp_zero equal to the ALU model for opcode 1, rsp_err=0.
- All four requesters valid continuously, Cards 1..4, rsp_ready=1: grants in order 0,1,2,3,0; each response 3 cycles apart with matching rsp_id.
- Illegal opcode Card=5'b00000 from requester 2, then Card=5'b10001: rsp_valid at T+1 with rsp_err=1, rsp_f=0, rsp_cout=0, rsp_zero=0; alu_card not used for issue.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_* stable, req_ready=0, busy=1.
  - A new request is accepted only the cycle after the handshake.
- Reset mid-op: drop rst_n in ISSUE.
  - All outputs 0 immediately.
  - After release, requester 1 (previously waiting) is granted first from pointer 0.
  - No stale response appears.
- With ALU_ARB_STATS_EN: 3 legal ops from requester 1 and 1 illegal op from requester 3 -> stat_ops[1]=3, stat_err=1, other counters 0.
